// File: rtl/mpx_pilot_seq.sv
// Stereo MPX pilot sequencer: soft-starts/stops the 19 kHz pilot gain and only
// retunes the pilot DDS while the gain is held at zero, so retunes are click-free.
module mpx_pilot_seq #(
  parameter int GAIN_WIDTH = 16,
  parameter int STEP_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  enable,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic [GAIN_WIDTH-1:0] ramp_inc,
  input  logic [DIV_WIDTH-1:0]  ramp_div,
  input  logic                  step_req,
  input  logic [STEP_WIDTH-1:0] step_in,
  output logic [GAIN_WIDTH-1:0] pilot_gain,
  output logic [STEP_WIDTH-1:0] dds_step,
  output logic                  step_ack,
  output logic                  stereo_ok,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    RUN    = 3'd2,
    DOWN   = 3'd3,
    RETUNE = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    pending;
  logic [STEP_WIDTH-1:0]   pend_step;
  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [GAIN_WIDTH-1:0]   inc_eff;
  logic [GAIN_WIDTH-1:0]   gain_toward;
  logic [GAIN_WIDTH-1:0]   gain_down;
  logic                    upd;

  // Differences are compared before adding/subtracting so the ramp can never wrap or overshoot.
  always_comb begin
    inc_eff     = (ramp_inc == '0) ? GAIN_WIDTH'(1) : ramp_inc;
    gain_toward = pilot_gain;
    if (pilot_gain < target_gain)
      gain_toward = ((target_gain - pilot_gain) > inc_eff) ? (pilot_gain + inc_eff) : target_gain;
    else if (pilot_gain > target_gain)
      gain_toward = ((pilot_gain - target_gain) > inc_eff) ? (pilot_gain - inc_eff) : target_gain;
    gain_down = (pilot_gain > inc_eff) ? (pilot_gain - inc_eff) : '0;
  end

  assign upd       = tick && (div_cnt == ramp_div);
  assign stereo_ok = (state_q == RUN);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pilot_gain <= '0;
      dds_step   <= '0;
      step_ack   <= 1'b0;
      pending    <= 1'b0;
      pend_step  <= '0;
      div_cnt    <= '0;
    end else begin
      step_ack <= 1'b0;
      if (tick)
        div_cnt <= upd ? '0 : (div_cnt + DIV_WIDTH'(1));
      // Outside IDLE a request is parked; the latest request wins.
      if (step_req && (state_q != IDLE)) begin
        pending   <= 1'b1;
        pend_step <= step_in;
      end

      case (state_q)
        IDLE: begin
          pilot_gain <= '0;
          if (step_req) begin
            dds_step <= step_in;
            step_ack <= 1'b1;
            pending  <= 1'b0;
          end else if (pending) begin
            dds_step <= pend_step;
            step_ack <= 1'b1;
            pending  <= 1'b0;
          end
          if (enable) begin
            state_q <= UP;
            div_cnt <= '0;
          end
        end
        UP: begin
          if (upd) begin
            if (!enable || pending) begin
              state_q <= DOWN;
            end else begin
              pilot_gain <= gain_toward;
              if (gain_toward == target_gain)
                state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!enable || pending) begin
            state_q <= DOWN;
            div_cnt <= '0;
          end else if (target_gain != pilot_gain) begin
            state_q <= UP;
            div_cnt <= '0;
          end
        end
        DOWN: begin
          if (upd) begin
            if (enable && !pending) begin
              state_q <= UP;
            end else begin
              pilot_gain <= gain_down;
              if (gain_down == '0)
                state_q <= pending ? RETUNE : IDLE;
            end
          end
        end
        RETUNE: begin
          dds_step <= pend_step;
          step_ack <= 1'b1;
          pending  <= step_req;
          state_q  <= enable ? UP : IDLE;
          div_cnt  <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpx_pilot_seq.sv
// Bench for mpx_pilot_seq: hand-derived vector table for the ramp/retune corner cases,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mpx_pilot_seq;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic        enable;
  logic [15:0] target_gain;
  logic [15:0] ramp_inc;
  logic [15:0] ramp_div;
  logic        step_req;
  logic [31:0] step_in;
  logic [15:0] pilot_gain;
  logic [31:0] dds_step;
  logic        step_ack;
  logic        stereo_ok;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  mpx_pilot_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .enable      (enable),
    .target_gain (target_gain),
    .ramp_inc    (ramp_inc),
    .ramp_div    (ramp_div),
    .step_req    (step_req),
    .step_in     (step_in),
    .pilot_gain  (pilot_gain),
    .dds_step    (dds_step),
    .step_ack    (step_ack),
    .stereo_ok   (stereo_ok),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rn, en, tk, req, tgt, inc, div;
    logic [31:0] sin;
    int          ncyc;
    int          e_gain, e_state;
    logic [31:0] e_dds;
    int          e_ack;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: plain integers, phase numbers match the status readback codes.
  int          m_state, m_gain, m_cnt;
  bit          m_ack, m_pend;
  logic [31:0] m_dds, m_pstep;

  function automatic void add(int rn, int en, int tk, int req, int tgt, int inc, int div,
                              logic [31:0] sin, int n, int eg, int es, logic [31:0] ed, int ea);
    vec_t v;
    v.rn = rn; v.en = en; v.tk = tk; v.req = req; v.tgt = tgt; v.inc = inc; v.div = div;
    v.sin = sin; v.ncyc = n; v.e_gain = eg; v.e_state = es; v.e_dds = ed; v.e_ack = ea;
    vecs.push_back(v);
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic modelClock();
    int  inc, ncnt, nstate, ngain, tgt;
    bit  upd;
    if (!reset_n) begin
      m_state = 0; m_gain = 0; m_cnt = 0; m_ack = 0; m_pend = 0; m_dds = '0; m_pstep = '0;
      return;
    end
    tgt    = int'(target_gain);
    inc    = (ramp_inc == 16'd0) ? 1 : int'(ramp_inc);
    upd    = tick && (m_cnt == int'(ramp_div));
    ncnt   = !tick ? m_cnt : (upd ? 0 : (m_cnt + 1) % 65536);
    nstate = m_state;
    ngain  = m_gain;
    m_ack  = 0;
    case (m_state)
      0: begin
        if (step_req) begin
          m_dds = step_in; m_ack = 1; m_pend = 0;
        end else if (m_pend) begin
          m_dds = m_pstep; m_ack = 1; m_pend = 0;
        end
        if (enable) nstate = 1;
      end
      1: if (upd) begin
        if (!enable || m_pend) nstate = 3;
        else begin
          ngain = (m_gain < tgt) ? imin(m_gain + inc, tgt) : imax(m_gain - inc, tgt);
          if (ngain == tgt) nstate = 2;
        end
      end
      2: begin
        if (!enable || m_pend) nstate = 3;
        else if (tgt != m_gain) nstate = 1;
      end
      3: if (upd) begin
        if (enable && !m_pend) nstate = 1;
        else begin
          ngain = imax(m_gain - inc, 0);
          if (ngain == 0) nstate = m_pend ? 4 : 0;
        end
      end
      default: begin
        m_dds = m_pstep; m_ack = 1; m_pend = 0;
        nstate = enable ? 1 : 0;
      end
    endcase
    if (step_req && m_state != 0) begin
      m_pend = 1; m_pstep = step_in;
    end
    if (nstate != m_state) ncnt = 0;
    m_state = nstate;
    m_gain  = ngain;
    m_cnt   = ncnt;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    reset_n     = (v.rn != 0);
    enable      = (v.en != 0);
    tick        = (v.tk != 0);
    step_req    = (v.req != 0);
    target_gain = 16'(v.tgt);
    ramp_inc    = 16'(v.inc);
    ramp_div    = 16'(v.div);
    step_in     = v.sin;
  endtask

  task automatic stepCycle();
    modelClock();
    @(posedge clk);
    #1;
    checkOutput("model gain",   32'(pilot_gain), 32'(m_gain));
    checkOutput("model state",  32'(state),      32'(m_state));
    checkOutput("model dds",    dds_step,        m_dds);
    checkOutput("model ack",    32'(step_ack),   32'(m_ack));
    checkOutput("model stereo", 32'(stereo_ok),  32'(m_state == 2));
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; tick = 1'b0; step_req = 1'b0;
    target_gain = '0; ramp_inc = '0; ramp_div = '0; step_in = '0;
    m_state = 0; m_gain = 0; m_cnt = 0; m_ack = 0; m_pend = 0; m_dds = '0; m_pstep = '0;

    // rn en tk rq tgt    inc   div sin            n | gain  st dds            ack
    add(0, 1, 1, 1, 'h100, 'h40, 3, 32'h55,        2,  0,    0, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 3, 32'h0,         1,  0,    1, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 3, 32'h0,         4,  'h40, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 3, 32'h0,         4,  'h80, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 3, 32'h0,         4,  'hC0, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 3, 32'h0,         4,  'h100,2, 32'h0,         0);
    add(0, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         1,  0,    0, 32'h0,         0);
    add(1, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         1,  0,    1, 32'h0,         0);
    add(1, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         1,  'h40, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         1,  'h80, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         1,  'hA0, 2, 32'h0,         0);
    add(1, 1, 1, 0, 'hA0,  'h40, 0, 32'h0,         3,  'hA0, 2, 32'h0,         0);
    add(0, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    0, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         5,  'h100,2, 32'h0,         0);
    add(1, 1, 1, 1, 'h100, 'h40, 0, 32'h0A3D70A4,  1,  'h100,2, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h100,3, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         3,  'h40, 3, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    4, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    1, 32'h0A3D70A4,  1);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h40, 1, 32'h0A3D70A4,  0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         3,  'h100,2, 32'h0A3D70A4,  0);
    add(1, 1, 1, 1, 'h100, 'h40, 0, 32'h1111,      1,  'h100,2, 32'h0A3D70A4,  0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h100,3, 32'h0A3D70A4,  0);
    add(1, 1, 1, 1, 'h100, 'h40, 0, 32'h2222,      1,  'hC0, 3, 32'h0A3D70A4,  0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         3,  0,    4, 32'h0A3D70A4,  0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    1, 32'h2222,      1);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h40, 1, 32'h2222,      0);
    add(1, 1, 0, 0, 'h100, 'h40, 0, 32'h0,         5,  'h40, 1, 32'h2222,      0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h80, 1, 32'h2222,      0);
    add(0, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    0, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         3,  'h80, 1, 32'h0,         0);
    add(1, 0, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h80, 3, 32'h0,         0);
    add(1, 0, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h40, 3, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h40, 1, 32'h0,         0);
    add(1, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  'h80, 1, 32'h0,         0);
    add(0, 1, 1, 0, 'h100, 'h40, 0, 32'h0,         1,  0,    0, 32'h0,         0);
    add(1, 1, 1, 0, 0,     0,    0, 32'h0,         1,  0,    1, 32'h0,         0);
    add(1, 1, 1, 0, 0,     0,    0, 32'h0,         1,  0,    2, 32'h0,         0);
    add(1, 1, 1, 0, 3,     0,    0, 32'h0,         1,  0,    1, 32'h0,         0);
    add(1, 1, 1, 0, 3,     0,    0, 32'h0,         3,  3,    2, 32'h0,         0);
    add(1, 0, 1, 0, 3,     0,    0, 32'h0,         1,  3,    3, 32'h0,         0);
    add(1, 0, 1, 0, 3,     0,    0, 32'h0,         3,  0,    0, 32'h0,         0);
    add(1, 0, 1, 1, 3,     0,    0, 32'hDEADBEEF,  1,  0,    0, 32'hDEADBEEF,  1);
    add(1, 0, 1, 0, 3,     0,    0, 32'h0,         1,  0,    0, 32'hDEADBEEF,  0);

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      repeat (vecs[i].ncyc) stepCycle();
      checkOutput($sformatf("vec%0d gain", i),   32'(pilot_gain), 32'(vecs[i].e_gain));
      checkOutput($sformatf("vec%0d state", i),  32'(state),      32'(vecs[i].e_state));
      checkOutput($sformatf("vec%0d dds", i),    dds_step,        vecs[i].e_dds);
      checkOutput($sformatf("vec%0d ack", i),    32'(step_ack),   32'(vecs[i].e_ack));
      checkOutput($sformatf("vec%0d stereo", i), 32'(stereo_ok),  32'(vecs[i].e_state == 2));
    end

    // Randomized traffic; the divider setting only moves while reset is held.
    for (int c = 0; c < 4000; c++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      if (!reset_n) ramp_div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      tick     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0: target_gain = 16'h0000;
          1: target_gain = 16'h0001;
          2: target_gain = 16'h00A0;
          3: target_gain = 16'h0100;
          4: target_gain = 16'hFFFF;
          default: target_gain = 16'($urandom_range(0, 16'h01FF));
        endcase
      end
      if ($urandom_range(0, 79) == 0) ramp_inc = 16'($urandom_range(0, 16'h0080));
      step_req = ($urandom_range(0, 24) == 0);
      step_in  = $urandom;
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
